// File: rtl/rv32_if_stage.sv
// RV32 instruction-fetch stage: single-outstanding memory request, one-entry skid buffer
// for downstream stalls, and redirect handling that drains an in-flight response.
module rv32_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        ifid_valid,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

   localparam logic [31:0] ResetPc4 = RESET_PC + 32'd4;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] skid_q, skid_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_ir_q, ifid_ir_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_plus4;

   // Targets are word aligned; the low two bits of the redirect are dropped.
   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
   assign pc_plus4     = pc_q + 32'd4;

   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         skid_q       <= '0;
         ifid_valid_q <= 1'b0;
         ifid_ir_q    <= NOP_INSN;
         ifid_pc_q    <= RESET_PC;
         ifid_pc4_q   <= ResetPc4;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         skid_q       <= skid_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_ir_q    <= ifid_ir_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      skid_d       = skid_q;
      ifid_valid_d = ifid_valid_q;
      ifid_ir_d    = ifid_ir_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;

      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
            if (redirect_i) begin
               pc_d         = redirect_tgt;
               ifid_valid_d = 1'b0;
               ifid_ir_d    = NOP_INSN;
            end
         end
         StFetch: begin
            if (redirect_i) begin
               pc_d         = redirect_tgt;
               ifid_valid_d = 1'b0;
               ifid_ir_d    = NOP_INSN;
               if (!imem_rvalid) begin
                  // Request still in flight: keep presenting it until it completes.
                  addr_d  = pc_q;
                  state_d = StDrain;
               end
            end else if (imem_rvalid) begin
               if (stall_i) begin
                  skid_d  = imem_rdata;
                  state_d = StHold;
               end else begin
                  ifid_valid_d = 1'b1;
                  ifid_ir_d    = imem_rdata;
                  ifid_pc_d    = pc_q;
                  ifid_pc4_d   = pc_plus4;
                  pc_d         = pc_plus4;
               end
            end else if (!stall_i) begin
               ifid_valid_d = 1'b0;
               ifid_ir_d    = NOP_INSN;
            end
         end
         StHold: begin
            if (redirect_i) begin
               pc_d         = redirect_tgt;
               skid_d       = '0;
               ifid_valid_d = 1'b0;
               ifid_ir_d    = NOP_INSN;
               state_d      = StFetch;
            end else if (!stall_i) begin
               ifid_valid_d = 1'b1;
               ifid_ir_d    = skid_q;
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = pc_plus4;
               pc_d         = pc_plus4;
               state_d      = StFetch;
            end
         end
         StDrain: begin
            if (redirect_i) begin
               pc_d         = redirect_tgt;
               ifid_valid_d = 1'b0;
               ifid_ir_d    = NOP_INSN;
            end
            if (imem_rvalid) begin
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign imem_req   = (state_q == StFetch) || (state_q == StDrain);
   assign imem_addr  = (state_q == StDrain) ? addr_q : pc_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_ir    = ifid_ir_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_rv32_if_stage.sv
// Directed bench for rv32_if_stage: fetch streaming, stall/skid, redirects, wrap and reset.
module tb_rv32_if_stage;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        ifid_valid;
   logic [31:0] ifid_ir;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   bit          auto_mem = 1'b0;

   always #5 clk = ~clk;

   rv32_if_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .ifid_valid    (ifid_valid),
      .ifid_ir       (ifid_ir),
      .ifid_pc       (ifid_pc),
      .ifid_pc4      (ifid_pc4)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Inputs are driven and outputs sampled at the falling edge.
   task automatic cyc();
      if (auto_mem) begin
         imem_rvalid = imem_req;
         imem_rdata  = mem_word(imem_addr);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, ".req"},   {31'd0, imem_req},   32'd0);
      check_eq({tag, ".addr"},  imem_addr,           32'h0);
      check_eq({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
      check_eq({tag, ".ir"},    ifid_ir,             Nop);
      check_eq({tag, ".pc"},    ifid_pc,             32'h0);
      check_eq({tag, ".pc4"},   ifid_pc4,            32'h4);
   endtask

   initial begin
      rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      @(negedge clk);
      cyc(); cyc();
      check_reset("rst");

      // Streaming fetch
      rst_n = 1'b1; auto_mem = 1'b1;
      cyc();
      check_eq("first_req", {31'd0, imem_req}, 32'd1);
      check_eq("first_addr", imem_addr, 32'h0);
      cyc();
      check_eq("s0.pc", ifid_pc, 32'h0);
      check_eq("s0.ir", ifid_ir, mem_word(32'h0));
      check_eq("s0.valid", {31'd0, ifid_valid}, 32'd1);
      cyc();
      check_eq("s1.pc", ifid_pc, 32'h4);
      check_eq("s1.ir", ifid_ir, mem_word(32'h4));
      check_eq("s1.pc4", ifid_pc4, 32'h8);

      // Stall while response to 0x8 arrives
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_eq("hold.req", {31'd0, imem_req}, 32'd0);
         check_eq("hold.pc", ifid_pc, 32'h4);
      end
      stall_i = 1'b0;
      cyc();
      check_eq("rel.pc", ifid_pc, 32'h8);
      check_eq("rel.ir", ifid_ir, mem_word(32'h8));
      check_eq("rel.addr", imem_addr, 32'hC);

      // Redirect with 0xC outstanding, answered two cycles later
      auto_mem = 1'b0; imem_rvalid = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      cyc();
      redirect_i = 1'b0;
      check_eq("drn.valid", {31'd0, ifid_valid}, 32'd0);
      check_eq("drn.ir", ifid_ir, Nop);
      check_eq("drn.addr", imem_addr, 32'hC);
      check_eq("drn.req", {31'd0, imem_req}, 32'd1);
      cyc();
      check_eq("drn2.addr", imem_addr, 32'hC);
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'hC);
      cyc();
      check_eq("drn3.addr", imem_addr, 32'h100);
      check_eq("drn3.valid", {31'd0, ifid_valid}, 32'd0);
      auto_mem = 1'b1;
      cyc();
      check_eq("tgt.pc", ifid_pc, 32'h100);
      check_eq("tgt.ir", ifid_ir, mem_word(32'h100));

      // Redirect to unaligned target with stall in same cycle
      redirect_i = 1'b1; redirect_pc_i = 32'h203; stall_i = 1'b1;
      cyc();
      check_eq("rs.valid", {31'd0, ifid_valid}, 32'd0);
      check_eq("rs.ir", ifid_ir, Nop);
      check_eq("rs.addr", imem_addr, 32'h200);
      redirect_i = 1'b0; stall_i = 1'b0;
      cyc();
      check_eq("rs2.pc", ifid_pc, 32'h200);
      check_eq("rs2.ir", ifid_ir, mem_word(32'h200));

      // Redirect while in HOLD drops the skid entry
      stall_i = 1'b1;
      cyc();
      redirect_i = 1'b1; redirect_pc_i = 32'h300;
      cyc();
      check_eq("rh.valid", {31'd0, ifid_valid}, 32'd0);
      check_eq("rh.addr", imem_addr, 32'h300);
      check_eq("rh.req", {31'd0, imem_req}, 32'd1);
      redirect_i = 1'b0; stall_i = 1'b0;
      cyc();
      check_eq("rh2.pc", ifid_pc, 32'h300);
      check_eq("rh2.ir", ifid_ir, mem_word(32'h300));

      // Back-to-back redirects in DRAIN: last one wins
      auto_mem = 1'b0; imem_rvalid = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h400;
      cyc();
      check_eq("lw.addr", imem_addr, 32'h304);
      redirect_pc_i = 32'h500;
      cyc();
      redirect_i = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      check_eq("lw2.addr", imem_addr, 32'h500);
      check_eq("lw2.valid", {31'd0, ifid_valid}, 32'd0);

      // PC wrap
      auto_mem = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      cyc();
      redirect_i = 1'b0;
      cyc();
      check_eq("wrap.pc", ifid_pc, 32'hFFFF_FFFC);
      check_eq("wrap.pc4", ifid_pc4, 32'h0);
      check_eq("wrap.addr", imem_addr, 32'h0);

      // Reset from HOLD
      stall_i = 1'b1;
      cyc();
      check_eq("rh0.req", {31'd0, imem_req}, 32'd0);
      rst_n = 1'b0; stall_i = 1'b0;
      cyc();
      check_reset("rst_hold");
      rst_n = 1'b1;
      cyc();
      check_eq("rh_rel.req", {31'd0, imem_req}, 32'd1);
      check_eq("rh_rel.addr", imem_addr, 32'h0);

      // Reset from DRAIN, with a stale response arriving during reset
      cyc();
      check_eq("pre_drn.pc", ifid_pc, 32'h0);
      auto_mem = 1'b0; imem_rvalid = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      cyc();
      check_eq("rd0.addr", imem_addr, 32'h4);
      redirect_i = 1'b0; rst_n = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'h4);
      cyc();
      check_reset("rst_drain");
      imem_rvalid = 1'b0; rst_n = 1'b1;
      cyc();
      check_eq("rd_rel.req", {31'd0, imem_req}, 32'd1);
      check_eq("rd_rel.addr", imem_addr, 32'h0);
      check_eq("rd_rel.valid", {31'd0, ifid_valid}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
      cyc();
      check_eq("rd_f.pc", ifid_pc, 32'h0);
      check_eq("rd_f.ir", ifid_ir, mem_word(32'h0));
      check_eq("rd_f.addr", imem_addr, 32'h4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
